// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared RV32I core types and constants (XLEN, bubble NOP,
//            IF-stage state encoding, address alignment helper).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 - decodes to a harmless no-op in ID
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } if_state_t;

    // Instruction fetches are always word aligned; low address bits are dropped
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register. flush_i loads a bubble (valid 0, NOP,
//            PC kept), load_i captures a fetched instruction, otherwise the
//            contents are held.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] inst_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;

    // Flush wins over load; neither asserted means hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;
    assign inst_o     = inst_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : RV32I instruction-fetch stage. Owns the PC, issues word-aligned
//            I-cache requests, absorbs stalls and EX redirects, and feeds the
//            IF/ID register. A redirect that arrives while a fetch is still
//            outstanding is parked in tgt_q (DRAIN) until that fetch returns,
//            so the request address never changes before icache_ready_i.
//            Optional macro IF_PERF_CNT_EN adds fetch/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_ready_i,
    input  logic [31:0] icache_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o,
    output logic [31:0] id_inst_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_miss_o
`endif
);

    if_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            ifid_load;
    logic            ifid_flush;
    logic [XLEN-1:0] redir_tgt;

    assign redir_tgt = word_align(redirect_pc_i);

    // Next-state, next-PC and IF/ID control selection
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect_i) begin
                    ifid_flush = 1'b1;
                    if (icache_ready_i) begin
                        pc_d = redir_tgt;
                    end else begin
                        tgt_d   = redir_tgt;
                        state_d = DRAIN;
                    end
                end else if (stall_i) begin
                    // hold everything; any returned data is re-requested
                end else if (icache_ready_i) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + 32'd4;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            DRAIN: begin
                ifid_flush = 1'b1;
                if (redirect_i) begin
                    tgt_d = redir_tgt;
                end
                if (icache_ready_i) begin
                    pc_d    = redirect_i ? redir_tgt : tgt_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // FSM, fetch PC and pending redirect target registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    assign icache_req_o  = rst_n;
    assign icache_addr_o = pc_q;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ifid_load),
        .flush_i    (ifid_flush),
        .pc_i       (pc_q),
        .inst_i     (icache_rdata_i),
        .valid_o    (id_valid_o),
        .pc_o       (id_pc_o),
        .pc_plus4_o (id_pc_plus4_o),
        .inst_o     (id_inst_o)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_miss_q;

    // Delivered-instruction and cache-miss-cycle counters, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_miss_q  <= '0;
        end else begin
            if (ifid_load) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (icache_req_o && !icache_ready_i) begin
                perf_miss_q <= perf_miss_q + 32'd1;
            end
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_miss_o  = perf_miss_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage: directed stimulus, a
//            fetch-stage reference model and hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hDEAD_0003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_miss;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instruction memory: each word's content is derived from its address
    assign rdata = addr ^ SALT;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall),
        .redirect_i     (redir),
        .redirect_pc_i  (redir_pc),
        .icache_req_o   (req),
        .icache_addr_o  (addr),
        .icache_ready_i (rdy),
        .icache_rdata_i (rdata),
        .id_valid_o     (id_valid),
        .id_pc_o        (id_pc),
        .id_pc_plus4_o  (id_pc4),
        .id_inst_o      (id_inst)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o   (perf_fetch),
        .perf_miss_o    (perf_miss)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks: the address the fetch unit must be requesting, whether a
    // redirect is parked waiting for the outstanding fetch, and what the
    // decode stage should be looking at.
    logic [31:0] m_req_addr;
    logic [31:0] m_parked;
    bit          m_waiting;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_nfetch;
    logic [31:0] m_nmiss;

    function automatic logic [31:0] align(input logic [31:0] a);
        logic [31:0] r;
        r = a;
        r[1:0] = 2'b00;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req_addr = 32'h0;
            m_parked   = 32'h0;
            m_waiting  = 0;
            m_valid    = 0;
            m_pc       = 32'h0;
            m_inst     = NOP;
            m_nfetch   = 32'h0;
            m_nmiss    = 32'h0;
        end else begin
            if (!rdy) m_nmiss = m_nmiss + 1;
            if (m_waiting) begin
                // outstanding fetch belongs to a squashed path
                m_valid = 0;
                m_inst  = NOP;
                if (redir) m_parked = align(redir_pc);
                if (rdy) begin
                    m_req_addr = m_parked;
                    m_waiting  = 0;
                end
            end else if (redir) begin
                m_valid = 0;
                m_inst  = NOP;
                if (rdy) m_req_addr = align(redir_pc);
                else begin
                    m_parked  = align(redir_pc);
                    m_waiting = 1;
                end
            end else if (stall) begin
                // decode frozen, same address re-requested
            end else if (rdy) begin
                m_valid    = 1;
                m_pc       = m_req_addr;
                m_inst     = m_req_addr ^ SALT;
                m_req_addr = m_req_addr + 32'd4;
                m_nfetch   = m_nfetch + 1;
            end else begin
                m_valid = 0;
                m_inst  = NOP;
            end
        end
    end

    // Every cycle out of reset, DUT outputs must match the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("req",      {31'h0, req},      32'h1);
            chk("addr",     addr,              m_req_addr);
            chk("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
            chk("id_pc",    id_pc,             m_pc);
            chk("id_pc4",   id_pc4,            m_pc + 32'd4);
            chk("id_inst",  id_inst,           m_inst);
`ifdef IF_PERF_CNT_EN
            chk("perf_fetch", perf_fetch, m_nfetch);
            chk("perf_miss",  perf_miss,  m_nmiss);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input logic s, input logic r, input logic [31:0] rpc, input logic rd);
        stall    = s;
        redir    = r;
        redir_pc = rpc;
        rdy      = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 0; redir = 0; redir_pc = 0; rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'h0, req},      32'h0);
        chk("rst_addr",  addr,              32'h0);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_pc",    id_pc,             32'h0);
        chk("rst_pc4",   id_pc4,            32'h4);
        chk("rst_inst",  id_inst,           NOP);
        rst_n = 1'b1;

        // streaming at one instruction per cycle
        repeat (3) tick(0, 0, 0, 1);
        chk("stream_pc",    id_pc,             32'h8);
        chk("stream_valid", {31'h0, id_valid}, 32'h1);
        chk("stream_inst",  id_inst,           32'h8 ^ SALT);

        // stall freezes IF/ID, nothing skipped afterwards
        repeat (2) tick(1, 0, 0, 1);
        chk("stall_pc",   id_pc, 32'h8);
        chk("stall_addr", addr,  32'hC);
        tick(0, 0, 0, 1);
        chk("post_stall_pc", id_pc, 32'hC);

        // three miss cycles at 0x10 give three bubbles
        repeat (3) tick(0, 0, 0, 0);
        chk("miss_inst",  id_inst,           NOP);
        chk("miss_valid", {31'h0, id_valid}, 32'h0);
        chk("miss_addr",  addr,              32'h10);
        tick(0, 0, 0, 1);
        chk("miss_done_pc", id_pc, 32'h10);

        // redirect to 0x100 while 0x20 is outstanding
        repeat (3) tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(0, 1, 32'h100, 0);
        chk("drain_addr_hold", addr, 32'h20);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        chk("drain_to_0x100", addr,              32'h100);
        chk("drain_no_valid", {31'h0, id_valid}, 32'h0);
        tick(0, 0, 0, 1);
        chk("redir_pc_0x100", id_pc, 32'h100);

        // two redirects in one miss: the newest wins
        tick(0, 0, 0, 0);
        tick(0, 1, 32'h200, 0);
        tick(0, 1, 32'h300, 0);
        tick(0, 0, 0, 1);
        chk("newest_wins", addr, 32'h300);

        // misaligned redirect with ready in the same cycle
        tick(0, 1, 32'h303, 1);
        chk("align_addr", addr, 32'h300);
        tick(0, 0, 0, 1);
        chk("align_pc", id_pc, 32'h300);

        // redirect flushes even under stall; redirect with ready in DRAIN
        tick(1, 1, 32'h400, 0);
        chk("stall_flush", {31'h0, id_valid}, 32'h0);
        tick(0, 1, 32'h500, 1);
        chk("drain_redir_ready", addr, 32'h500);

        // PC wrap at top of address space
        tick(0, 1, 32'hFFFF_FFFC, 1);
        tick(0, 0, 0, 1);
        chk("wrap_pc",   id_pc,  32'hFFFF_FFFC);
        chk("wrap_pc4",  id_pc4, 32'h0);
        chk("wrap_addr", addr,   32'h0);

        // asynchronous reset in the middle of DRAIN
        tick(0, 0, 0, 0);
        tick(0, 1, 32'h700, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req",   {31'h0, req},      32'h0);
        chk("async_addr",  addr,              32'h0);
        chk("async_valid", {31'h0, id_valid}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(0, 0, 0, 1);
        chk("post_rst_pc",    id_pc,             32'h0);
        chk("post_rst_valid", {31'h0, id_valid}, 32'h1);

        // 10 delivered, 4 miss cycles since reset
        repeat (2) tick(0, 0, 0, 0);
        repeat (4) tick(0, 0, 0, 1);
        repeat (2) tick(0, 0, 0, 0);
        repeat (5) tick(0, 0, 0, 1);
        chk("ten_fetch_pc", id_pc, 32'h24);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch_lit", perf_fetch, 32'd10);
        chk("perf_miss_lit",  perf_miss,  32'd4);
`endif

        tick(0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RV32I core: owns the PC, drives the instruction-cache request interface, and holds the IF/ID pipeline register whose instruction output feeds immediate generation and decode in ID. It absorbs hazard-unit stalls, branch/jump redirects from EX, and variable cache latency.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- stall_i  in  1  hazard unit: hold PC and IF/ID contents.
- redirect_i  in  1  EX: taken branch/jal/jalr this cycle.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 00).
- icache_req_o  out  1  fetch request.
- icache_addr_o  out  32  fetch address, word-aligned.
- icache_ready_i  in  1  icache_rdata_i valid for icache_addr_o this cycle.
- icache_rdata_i  in  32  fetched instruction.
- id_valid_o  out  1  IF/ID holds a real instruction.
- id_pc_o  out  32  PC of id_inst_o.
- id_pc_plus4_o  out  32  id_pc_o + 4 (link value).
- id_inst_o  out  32  instruction to ID.

## Operation
- State pc_q (outstanding fetch address), tgt_q (pending redirect target), FSM {FETCH, DRAIN}.
- icache_req_o = 1 whenever rst_n is high; icache_addr_o = pc_q. Address must stay stable until icache_ready_i; a request is never withdrawn.
- FETCH, priority order:
  - redirect_i: IF/ID flushed (valid 0, inst NOP) regardless of stall_i. If icache_ready_i: pc_q <= target, stay FETCH, data discarded. Else tgt_q <= target, go DRAIN.
  - stall_i: pc_q and IF/ID held. Data returned this cycle is discarded; same address re-requested.
  - icache_ready_i: IF/ID <= {1, pc_q, rdata}; pc_q <= pc_q + 4.
  - otherwise: IF/ID loads bubble (valid 0, inst NOP, pc unchanged).
- DRAIN: IF/ID holds bubble; returned data always discarded. redirect_i overwrites tgt_q (newest wins). On icache_ready_i: pc_q <= (redirect_i ? redirect_pc_i : tgt_q), go FETCH.
- Bubble instruction NOP = 32'h0000_0013 (addi x0,x0,0), so downstream decode is benign.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset: pc_q = RESET_PC, tgt_q = 0, FETCH, id_valid_o = 0, id_pc_o = 0, id_pc_plus4_o = 4, id_inst_o = NOP, icache_req_o = 0 during reset.
- Latency: ready at cycle N -> instruction on id_* in cycle N+1.
- Throughput: one instruction/cycle when icache_ready_i held high and no stall.
- Redirect with ready in same cycle: target requested cycle N+1. Redirect during miss: target requested cycle after pending fetch completes.
- Reset assertion mid-DRAIN or mid-miss aborts immediately; cache must tolerate abandoned request.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs perf_fetch_o[31:0] (instructions loaded into IF/ID with valid 1) and perf_miss_o[31:0] (cycles with icache_req_o high and icache_ready_i low); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package cpu_pkg: XLEN = 32, NOP_INST = 32'h0000_0013, if_state_t enum {FETCH, DRAIN}.
- One sub-module: if_id_reg (IF/ID register with load, hold, flush-to-bubble controls); FSM and PC logic in if_stage.

## Test plan
- Reset, ready held 1, no stall -> id_pc_o 0,4,8,... from cycle 2; id_valid_o 1 each cycle.
- Ready low 3 cycles at PC 0x10 -> three bubbles (id_inst_o 0x13), then PC 0x10 delivered once.
- stall_i high 2 cycles with id_pc_o = 0x8 -> id_* frozen at 0x8, then 0xC follows; no PC skipped.
- redirect_i to 0x100 during miss at 0x20, ready 2 cycles later -> 0x20 data dropped, next request 0x100, no valid instruction in between.
- Two redirects (0x200 then 0x300) during one miss -> fetch resumes at 0x300; redirect_pc_i 0x303 -> fetch at 0x300.
- With IF_PERF_CNT_EN: 10 delivered, 4 miss cycles -> perf_fetch_o = 10, perf_miss_o = 4.
